logic_unit_pipe: RTL and testbench
==================================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits; legal values are 1 to 64.
REQ-002 Parameter ACC_EN, default 1, enables accumulate mode; when 0, iAcc is ignored and treated as 0.
REQ-003 iClk  input  1  single clock; all state changes on its rising edge.
REQ-004 iRst  input  1  reset, asynchronous and active-high.
REQ-005 iValid  input  1  upstream request; the operand set is valid this cycle.
REQ-006 oReady  output  1  block accepts an operand set this cycle.
REQ-007 iOp  input  3  opcode: 000 AND, 001 OR, 010 NOT A, 011 XOR, 100 NAND, 101 NOR, 110 XNOR, 111 PASS B.
REQ-008 iA  input  WIDTH  operand A.
REQ-009 iB  input  WIDTH  operand B.
REQ-010 iAcc  input  1  when set, the accumulator replaces operand A.
REQ-011 oValid  output  1  result valid.
REQ-012 iReady  input  1  downstream accepts the result.
REQ-013 oY  output  WIDTH  result.
REQ-014 oZero  output  1  set when oY is all zeros.
REQ-015 oParity  output  1  XOR-reduction of oY.

Function
REQ-016 The block SHALL be a two-stage pipeline: S1 holds the operand register, S2 holds the result register.
REQ-017 An input transfer SHALL occur when iValid and oReady are both high; it loads iOp, iA, iB and iAcc into S1 and marks S1 valid.
REQ-018 An output transfer SHALL occur when oValid and iReady are both high.
REQ-019 S2 SHALL load from S1 when S1 is valid and either S2 is empty or an output transfer occurs in the same cycle.
- On that load, S2 computes the result from the S1 contents and the flags from the computed result.
REQ-020 oReady SHALL equal (S1 empty) OR (S1 moves to S2 this cycle), so that one transfer per cycle is sustained while iReady is high.
REQ-021 With iReady held high, latency from the input transfer edge to oValid SHALL be 2 cycles.
REQ-022 oValid SHALL reflect S2 valid; oY, oZero and oParity SHALL come directly from registers.
REQ-023 oY, oZero and oParity SHALL be stable while oValid is high and iReady is low.
REQ-024 The operand set SHALL be stable in S1 while the pipeline is stalled.
REQ-025 The accumulator SHALL be a WIDTH-bit register that takes the new result each time S2 loads.
REQ-026 When S1.iAcc is set and ACC_EN is 1, operand A SHALL be the accumulator value at the S1-to-S2 load.
- For back-to-back accumulate ops, this is the result of the immediately preceding operation.
REQ-027 NOT A SHALL ignore B, and PASS B SHALL ignore A.
REQ-028 All operations SHALL be bitwise; there is no carry and no width growth.
REQ-029 An input transfer and an output transfer in the same cycle SHALL both complete with no bubble and no lost data.
REQ-030 Operand sets SHALL never be dropped or duplicated, and results SHALL leave in input order.

Reset
REQ-031 Asserting iRst SHALL immediately clear the S1 and S2 valid bits, oY, the accumulator, oZero and oParity to 0.
REQ-032 While iRst is asserted, oReady SHALL be 1 and oValid SHALL be 0.
REQ-033 Reset mid-transfer SHALL discard all in-flight data; the first operand set accepted after release SHALL see an accumulator of 0.

Structure
REQ-034 Opcode constants (OP_AND through OP_PASSB) and the opcode width SHALL live in the shared package logic_pkg.
REQ-035 The combinational operation decode SHALL be a sub-module, logic_unit_core (inputs: op, a, b; output: y).
- It SHALL contain no state.
- The pipe module SHALL hold all registers and handshake logic.

Verification
REQ-036 Reset: WIDTH=8, assert iRst mid-stream -> oValid=0, oY=00, oReady=1 in the same cycle.
REQ-037 Opcode sweep: A=C3, B=A5, all eight ops, iReady=1 -> oY = 81, E7, 3C, 66, 7E, 18, 99, A5 in order, each 2 cycles after its input.
REQ-038 Accumulate: reset, then iAcc=1, OR with B=01, 02, 04 back-to-back -> oY = 01, 03, 07.
REQ-039 Backpressure: stream 10 operand sets, hold iReady=0 for 5 cycles mid-stream -> oReady falls once S1 and S2 are full; all 10 results appear in order with no loss.
REQ-040 Flags: XOR with A=5A, B=5A -> oY=00, oZero=1, oParity=0; then OR with A=01, B=00 -> oZero=0, oParity=1.
REQ-041 Full throughput: iValid=1 and iReady=1 for 16 cycles -> 16 results in 16 consecutive cycles after the 2-cycle latency.

Source files
------------

// File: rtl/logic_pkg.sv
// Shared opcode definitions for the bitwise logic unit pipeline.
package logic_pkg;

    localparam int OP_WIDTH = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_NOTA  = 3'b010,
        OP_XOR   = 3'b011,
        OP_NAND  = 3'b100,
        OP_NOR   = 3'b101,
        OP_XNOR  = 3'b110,
        OP_PASSB = 3'b111
    } opcode_e;

endpackage

// File: rtl/logic_unit_core.sv
// Stateless bitwise operation decode; selects one of eight logic functions of a and b.
module logic_unit_core
    import logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [WIDTH-1:0]    y
);

    // NOT A ignores b and PASS B ignores a; nothing here carries between bits
    always_comb begin
        y = '0;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_NOTA:  y = ~a;
            OP_XOR:   y = a ^ b;
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_XNOR:  y = ~(a ^ b);
            OP_PASSB: y = b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around logic_unit_core: S1 holds operands, S2 holds the
// registered result, flags and the accumulator that can stand in for operand A.
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ACC_EN = 1
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iValid,
    output logic                oReady,
    input  logic [OP_WIDTH-1:0] iOp,
    input  logic [WIDTH-1:0]    iA,
    input  logic [WIDTH-1:0]    iB,
    input  logic                iAcc,
    output logic                oValid,
    input  logic                iReady,
    output logic [WIDTH-1:0]    oY,
    output logic                oZero,
    output logic                oParity
);

    logic                s1Valid;
    logic [OP_WIDTH-1:0] s1Op;
    logic [WIDTH-1:0]    s1A;
    logic [WIDTH-1:0]    s1B;
    logic                s1Acc;

    logic                s2Valid;
    logic [WIDTH-1:0]    yReg;
    logic                zeroReg;
    logic                parityReg;
    logic [WIDTH-1:0]    accReg;

    logic                inXfer;
    logic                outXfer;
    logic                s2Load;
    logic [WIDTH-1:0]    operandA;
    logic [WIDTH-1:0]    coreY;

    // S1 may refill in the same cycle it hands off, which keeps one transfer per cycle
    assign outXfer = s2Valid & iReady;
    assign s2Load  = s1Valid & (~s2Valid | outXfer);
    assign oReady  = ~s1Valid | s2Load;
    assign inXfer  = iValid & oReady;

    assign operandA = ((ACC_EN != 0) && s1Acc) ? accReg : s1A;

    logic_unit_core #(
        .WIDTH(WIDTH)
    ) core (
        .op(s1Op),
        .a (operandA),
        .b (s1B),
        .y (coreY)
    );

    // Operand register: held unchanged while the downstream stage is stalled
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            s1Valid <= 1'b0;
            s1Op    <= '0;
            s1A     <= '0;
            s1B     <= '0;
            s1Acc   <= 1'b0;
        end else if (inXfer) begin
            s1Valid <= 1'b1;
            s1Op    <= iOp;
            s1A     <= iA;
            s1B     <= iB;
            s1Acc   <= iAcc;
        end else if (s2Load) begin
            s1Valid <= 1'b0;
        end
    end

    // Result register: flags are computed from the new result so all outputs are registered
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            s2Valid   <= 1'b0;
            yReg      <= '0;
            zeroReg   <= 1'b0;
            parityReg <= 1'b0;
            accReg    <= '0;
        end else if (s2Load) begin
            s2Valid   <= 1'b1;
            yReg      <= coreY;
            zeroReg   <= (coreY == '0);
            parityReg <= ^coreY;
            accReg    <= coreY;
        end else if (outXfer) begin
            s2Valid   <= 1'b0;
        end
    end

    assign oValid  = s2Valid;
    assign oY      = yReg;
    assign oZero   = zeroReg;
    assign oParity = parityReg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: table-driven opcode/flag/accumulate vectors plus
// streaming sequences for backpressure, throughput and mid-stream reset.
module tb_logic_unit_pipe;
    import logic_pkg::*;

    localparam int WIDTH = 8;

    logic             iClk = 1'b0;
    logic             iRst;
    logic             iValid;
    logic             oReady;
    logic [2:0]       iOp;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             iAcc;
    logic             oValid;
    logic             iReady;
    logic [WIDTH-1:0] oY;
    logic             oZero;
    logic             oParity;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expY;
        logic       expZero;
        logic       expParity;
    } vec_t;

    vec_t vecs[14];

    always #5 iClk = ~iClk;

    logic_unit_pipe #(
        .WIDTH (WIDTH),
        .ACC_EN(1)
    ) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iValid (iValid),
        .oReady (oReady),
        .iOp    (iOp),
        .iA     (iA),
        .iB     (iB),
        .iAcc   (iAcc),
        .oValid (oValid),
        .iReady (iReady),
        .oY     (oY),
        .oZero  (oZero),
        .oParity(oParity)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] op,
                                 input logic [7:0] a, input logic [7:0] b, input logic acc);
        iValid = valid;
        iOp    = op;
        iA     = a;
        iB     = b;
        iAcc   = acc;
    endtask

    task automatic nextCycle();
        @(posedge iClk);
        #1;
    endtask

    function automatic logic [7:0] modelY(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return a ^ b;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~(a ^ b);
            default: return b;
        endcase
    endfunction

    // Each vector must show up exactly two edges after it is presented, never one
    task automatic runVectors(input string tag, input int first, input int count,
                              input logic acc);
        for (int i = 0; i <= count; i++) begin
            if (i < count)
                applyStimulus(1'b1, vecs[first+i].op, vecs[first+i].a, vecs[first+i].b, acc);
            else
                applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
            #1;
            checkOutput({tag, " oReady"}, oReady, 1);
            nextCycle();
            if (i == 0) begin
                checkOutput({tag, " early oValid"}, oValid, 0);
            end else begin
                checkOutput({tag, " oValid"}, oValid, 1);
                checkOutput({tag, " oY"}, oY, vecs[first+i-1].expY);
                checkOutput({tag, " oZero"}, oZero, vecs[first+i-1].expZero);
                checkOutput({tag, " oParity"}, oParity, vecs[first+i-1].expParity);
            end
        end
        nextCycle();
        nextCycle();
    endtask

    task automatic streamTest(input string tag, input int n, input int stallStart,
                              input int stallLen, output int firstOut, output int lastOut,
                              output int received, output bit sawNotReady);
        logic [7:0] expQ[$];
        logic [7:0] heldY;
        logic [7:0] sa;
        logic [7:0] sb;
        bit         holding;
        bit         inNow;
        int         sent;
        sent        = 0;
        holding     = 0;
        received    = 0;
        firstOut    = -1;
        lastOut     = -1;
        sawNotReady = 0;
        heldY       = '0;
        for (int c = 0; c < 200 && received < n; c++) begin
            iReady = !(c >= stallStart && c < stallStart + stallLen);
            sa = 8'(sent * 29 + 3);
            sb = 8'h96 ^ 8'(sent);
            if (sent < n)
                applyStimulus(1'b1, 3'(sent % 8), sa, sb, 1'b0);
            else
                applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
            #1;
            if (!oReady) sawNotReady = 1;
            inNow = iValid && oReady;
            if (oValid && !iReady) begin
                if (holding) checkOutput({tag, " stall oY"}, oY, heldY);
                heldY   = oY;
                holding = 1;
            end else begin
                holding = 0;
            end
            if (oValid && iReady) begin
                if (expQ.size() == 0) begin
                    checkOutput({tag, " unexpected result"}, 1, 0);
                end else begin
                    checkOutput({tag, " oY"}, oY, expQ.pop_front());
                end
                received++;
                if (firstOut < 0) firstOut = c;
                lastOut = c;
            end
            if (inNow) begin
                expQ.push_back(modelY(3'(sent % 8), sa, sb));
                sent++;
            end
            nextCycle();
        end
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        iReady = 1'b1;
        checkOutput({tag, " result count"}, received, n);
    endtask

    initial begin
        int  firstOut;
        int  lastOut;
        int  received;
        bit  sawNotReady;

        vecs[0]  = '{OP_AND,   8'hC3, 8'hA5, 8'h81, 1'b0, 1'b0};
        vecs[1]  = '{OP_OR,    8'hC3, 8'hA5, 8'hE7, 1'b0, 1'b0};
        vecs[2]  = '{OP_NOTA,  8'hC3, 8'hA5, 8'h3C, 1'b0, 1'b0};
        vecs[3]  = '{OP_XOR,   8'hC3, 8'hA5, 8'h66, 1'b0, 1'b0};
        vecs[4]  = '{OP_NAND,  8'hC3, 8'hA5, 8'h7E, 1'b0, 1'b0};
        vecs[5]  = '{OP_NOR,   8'hC3, 8'hA5, 8'h18, 1'b0, 1'b0};
        vecs[6]  = '{OP_XNOR,  8'hC3, 8'hA5, 8'h99, 1'b0, 1'b0};
        vecs[7]  = '{OP_PASSB, 8'hC3, 8'hA5, 8'hA5, 1'b0, 1'b0};
        vecs[8]  = '{OP_XOR,   8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{OP_OR,    8'h01, 8'h00, 8'h01, 1'b0, 1'b1};
        vecs[10] = '{OP_OR,    8'hFF, 8'h01, 8'h01, 1'b0, 1'b1};
        vecs[11] = '{OP_OR,    8'hFF, 8'h02, 8'h03, 1'b0, 1'b0};
        vecs[12] = '{OP_OR,    8'hFF, 8'h04, 8'h07, 1'b0, 1'b1};
        vecs[13] = '{OP_OR,    8'hFF, 8'h01, 8'h01, 1'b0, 1'b1};

        iRst   = 1'b1;
        iReady = 1'b1;
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        #1;
        checkOutput("reset oValid", oValid, 0);
        checkOutput("reset oReady", oReady, 1);
        checkOutput("reset oY", oY, 0);
        checkOutput("reset oZero", oZero, 0);
        checkOutput("reset oParity", oParity, 0);
        #21;
        iRst = 1'b0;
        nextCycle();

        runVectors("sweep", 0, 8, 1'b0);
        runVectors("flags", 8, 2, 1'b0);

        iRst = 1'b1;
        #2;
        iRst = 1'b0;
        nextCycle();
        runVectors("accum", 10, 3, 1'b1);

        // Fill both stages with accumulate work, then reset between clock edges
        applyStimulus(1'b1, OP_OR, 8'hFF, 8'hF0, 1'b1);
        nextCycle();
        nextCycle();
        #3;
        iRst = 1'b1;
        #1;
        checkOutput("midreset oValid", oValid, 0);
        checkOutput("midreset oY", oY, 0);
        checkOutput("midreset oReady", oReady, 1);
        checkOutput("midreset oZero", oZero, 0);
        checkOutput("midreset oParity", oParity, 0);
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        #1;
        iRst = 1'b0;
        runVectors("postreset", 13, 1, 1'b1);

        streamTest("backpressure", 10, 4, 5, firstOut, lastOut, received, sawNotReady);
        checkOutput("backpressure oReady dropped", sawNotReady, 1);
        nextCycle();

        streamTest("throughput", 16, 1000, 0, firstOut, lastOut, received, sawNotReady);
        checkOutput("throughput first result cycle", firstOut, 2);
        checkOutput("throughput last result cycle", lastOut, 17);
        checkOutput("throughput oReady stayed high", sawNotReady, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
